// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between a requester and the bit-serial subtractor.
// SERIAL_SUB_FLAGS_EN adds the zero/ovf result flags.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (output start, a, b, bin,
                  input  busy, done, diff, bout, zero, ovf);
  modport slave  (input  start, a, b, bin,
                  output busy, done, diff, bout, zero, ovf);
`else
  modport master (output start, a, b, bin,
                  input  busy, done, diff, bout);
  modport slave  (input  start, a, b, bin,
                  output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell stepped LSB first.
// Optional macro SERIAL_SUB_FLAGS_EN adds registered zero/ovf result flags.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_sub_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, pd, pd_nxt, diff_q;
  logic             brw, bout_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       hs0, hs1;
  logic             cell_d, cell_b, accept, last;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             a_msb, b_msb, zero_q, ovf_q;
`endif

  // Half subtractor returns {borrow, difference}.
  function automatic logic [1:0] half_sub(input logic x, input logic y);
    return {~x & y, x ^ y};
  endfunction

  always_comb begin
    hs0    = half_sub(sa[0], sb[0]);
    hs1    = half_sub(hs0[0], brw);
    cell_d = hs1[0];
    cell_b = hs0[1] | hs1[1];
    pd_nxt = pd >> 1;
    pd_nxt[WIDTH-1] = cell_d;
  end

  assign accept = bus.start && ((state == IDLE) || (state == DONE));
  assign last   = (state == RUN) && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand shift registers, borrow FF, partial result and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      pd     <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      sa  <= bus.a;
      sb  <= bus.b;
      brw <= bus.bin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      brw <= cell_b;
      pd  <= pd_nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        diff_q <= pd_nxt;
        bout_q <= cell_b;
      end
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  // Operand sign bits are kept since sa/sb are consumed by the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (last) begin
      zero_q <= (pd_nxt == '0);
      ovf_q  <= (a_msb != b_msb) && (pd_nxt[WIDTH-1] != a_msb);
    end
  end

  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;
`endif

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule
